// File: rtl/jam_cost_loader_if.sv
// Bus bundle between the JAM cost loader and its environment: the cost-table
// stream, JAM's lookup/result signals and the captured result outputs.
interface jam_cost_loader_if #(
  parameter int COST_W = 7,
  parameter int CYC_W  = 24,
  parameter int IDX_W  = 3
);
  // Cost-table stream
  logic              in_valid;
  logic              in_ready;
  logic [COST_W-1:0] in_data;
  logic              in_last;

  // JAM engine side
  logic              JAM_RST;
  logic [IDX_W-1:0]  W;
  logic [IDX_W-1:0]  J;
  logic [COST_W-1:0] Cost;
  logic              Valid;
  logic [8:0]        MinCost;
  logic [3:0]        MatchCount;

  // Captured results and status
  logic              done;
  logic [8:0]        res_min_cost;
  logic [3:0]        res_match_count;
  logic [CYC_W-1:0]  res_cycles;
  logic              err_len;

  // The loader itself
  modport slave (
    input  in_valid, in_data, in_last,
    input  W, J, Valid, MinCost, MatchCount,
    output in_ready, JAM_RST, Cost,
    output done, res_min_cost, res_match_count, res_cycles, err_len
  );

  // Whatever drives the stream and plays the JAM engine
  modport master (
    output in_valid, in_data, in_last,
    output W, J, Valid, MinCost, MatchCount,
    input  in_ready, JAM_RST, Cost,
    input  done, res_min_cost, res_match_count, res_cycles, err_len
  );
endinterface

// File: rtl/jam_cost_loader.sv
// Loads an 8x8 cost table for the JAM engine from a valid/ready stream,
// serves JAM's combinational cost lookups, holds JAM in reset until a full
// table is present, then captures JAM's result and run length.
module jam_cost_loader #(
  parameter int WORKERS = 8,
  parameter int JOBS    = 8,
  parameter int COST_W  = 7,
  parameter int CYC_W   = 24
) (
  input  logic              CLK,
  input  logic              RST,
  jam_cost_loader_if.slave  bus
);

  localparam int DEPTH = WORKERS * JOBS;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + CYC_W'(1);
  endfunction

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                jam_rst_q, jam_rst_d;
  logic [8:0]          res_min_q, res_min_d;
  logic [3:0]          res_cnt_q, res_cnt_d;
  logic [CYC_W-1:0]    res_cyc_q, res_cyc_d;

  logic [COST_W-1:0]   table_q [DEPTH];
  logic                tbl_we;
  logic                in_ready;
  logic                beat;
  logic [IDX_W-1:0]    rd_idx;

  // The stream is stalled only while JAM is running on the table.
  assign in_ready = (state_q != S_RUN);
  assign beat     = bus.in_valid && in_ready;
  assign rd_idx   = {bus.W, bus.J};

  // Next-state, table write enable and result capture.
  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    cyc_d     = cyc_q;
    done_d    = done_q;
    err_d     = 1'b0;
    res_min_d = res_min_q;
    res_cnt_d = res_cnt_q;
    res_cyc_d = res_cyc_q;
    tbl_we    = 1'b0;

    unique case (state_q)
      // DONE leaves wr_idx at 0, so a beat arriving there is simply the
      // first beat of a new frame and follows the same length rules.
      S_LOAD, S_DONE: begin
        if (beat) begin
          tbl_we  = 1'b1;
          done_d  = 1'b0;
          state_d = S_LOAD;
          if ((wr_idx_q == LAST_IDX) && bus.in_last) begin
            state_d  = S_RUN;
            wr_idx_d = '0;
            cyc_d    = '0;
          end else if (bus.in_last || (wr_idx_q == LAST_IDX)) begin
            // Bad frame length: restart at entry 0; stale entries are
            // overwritten by the next frame.
            err_d    = 1'b1;
            wr_idx_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end

      S_RUN: begin
        cyc_d = sat_inc(cyc_q);
        if (bus.Valid) begin
          res_min_d = bus.MinCost;
          res_cnt_d = bus.MatchCount;
          res_cyc_d = sat_inc(cyc_q);
          done_d    = 1'b1;
          state_d   = S_DONE;
        end
      end

      default: begin
        state_d  = S_LOAD;
        wr_idx_d = '0;
      end
    endcase

    // JAM may only run while we are in RUN; registered so it is glitch-free.
    jam_rst_d = (state_d != S_RUN);
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_LOAD;
      wr_idx_q  <= '0;
      cyc_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      jam_rst_q <= 1'b1;
      res_min_q <= '0;
      res_cnt_q <= '0;
      res_cyc_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      cyc_q     <= cyc_d;
      done_q    <= done_d;
      err_q     <= err_d;
      jam_rst_q <= jam_rst_d;
      res_min_q <= res_min_d;
      res_cnt_q <= res_cnt_d;
      res_cyc_q <= res_cyc_d;
    end
  end

  // Cost table storage; deliberately not reset.
  always_ff @(posedge CLK) begin
    if (tbl_we) begin
      table_q[wr_idx_q] <= bus.in_data;
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.JAM_RST         = jam_rst_q;
  assign bus.Cost            = table_q[rd_idx];
  assign bus.done            = done_q;
  assign bus.err_len         = err_q;
  assign bus.res_min_cost    = res_min_q;
  assign bus.res_match_count = res_cnt_q;
  assign bus.res_cycles      = res_cyc_q;

endmodule

// File: tb/tb_jam_cost_loader.sv
// Directed testbench for jam_cost_loader: table loading, frame-length
// errors, run-length capture, reload from DONE and mid-operation reset.
module tb_jam_cost_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  jam_cost_loader_if #(.COST_W(7), .CYC_W(24), .IDX_W(3)) bus ();

  jam_cost_loader #(.WORKERS(8), .JOBS(8), .COST_W(7), .CYC_W(24)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one edge; back-to-back calls give no gaps.
  task automatic send_beat(input logic [6:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0d exp 1", bus.in_ready); end
    checks++; if (bus.JAM_RST !== 1'b1) begin errors++; $display("FAIL reset_jam_rst got %0d exp 1", bus.JAM_RST); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0d exp 0", bus.done); end
    checks++; if (bus.err_len !== 1'b0) begin errors++; $display("FAIL reset_err_len got %0d exp 0", bus.err_len); end
    checks++; if (bus.res_cycles !== 24'd0 || bus.res_min_cost !== 9'd0 || bus.res_match_count !== 4'd0) begin
      errors++; $display("FAIL reset_res got cyc=%0d min=%0d cnt=%0d exp 0/0/0", bus.res_cycles, bus.res_min_cost, bus.res_match_count); end
  endtask

  task automatic test_load();
    for (int i = 0; i < 63; i++) send_beat(7'(i), 1'b0);
    checks++; if (bus.JAM_RST !== 1'b1) begin errors++; $display("FAIL load_jam_rst_before_last got %0d exp 1", bus.JAM_RST); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL load_ready_before_last got %0d exp 1", bus.in_ready); end
    send_beat(7'd63, 1'b1);
    checks++; if (bus.JAM_RST !== 1'b0) begin errors++; $display("FAIL load_jam_rst_after_last got %0d exp 0", bus.JAM_RST); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL load_ready_in_run got %0d exp 0", bus.in_ready); end
    checks++; if (bus.err_len !== 1'b0) begin errors++; $display("FAIL load_no_err got %0d exp 0", bus.err_len); end
    bus.W = 3'd3; bus.J = 3'd5; #1;
    checks++; if (bus.Cost !== 7'd29) begin errors++; $display("FAIL load_cost_w3j5 got %0d exp 29", bus.Cost); end
    bus.W = 3'd7; bus.J = 3'd7; #1;
    checks++; if (bus.Cost !== 7'd63) begin errors++; $display("FAIL load_cost_w7j7 got %0d exp 63", bus.Cost); end
  endtask

  // Enters RUN at edge k (already done by caller); Valid sampled at k+100.
  task automatic test_run_result();
    bus.Valid = 1'b0;
    repeat (99) tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL run_done_early got %0d exp 0", bus.done); end
    checks++; if (bus.JAM_RST !== 1'b0) begin errors++; $display("FAIL run_jam_rst_low got %0d exp 0", bus.JAM_RST); end
    bus.Valid = 1'b1; bus.MinCost = 9'd300; bus.MatchCount = 4'd2;
    tick();
    bus.Valid = 1'b0;
    checks++; if (bus.res_cycles !== 24'd100) begin errors++; $display("FAIL run_res_cycles got %0d exp 100", bus.res_cycles); end
    checks++; if (bus.res_min_cost !== 9'd300) begin errors++; $display("FAIL run_res_min got %0d exp 300", bus.res_min_cost); end
    checks++; if (bus.res_match_count !== 4'd2) begin errors++; $display("FAIL run_res_cnt got %0d exp 2", bus.res_match_count); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL run_done got %0d exp 1", bus.done); end
    checks++; if (bus.JAM_RST !== 1'b1) begin errors++; $display("FAIL run_jam_rst_done got %0d exp 1", bus.JAM_RST); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL run_ready_done got %0d exp 1", bus.in_ready); end
    // Valid in DONE must be ignored.
    bus.Valid = 1'b1; bus.MinCost = 9'd5;
    tick();
    bus.Valid = 1'b0;
    checks++; if (bus.res_min_cost !== 9'd300) begin errors++; $display("FAIL done_ignores_valid got %0d exp 300", bus.res_min_cost); end
  endtask

  task automatic test_done_reload();
    send_beat(7'd7, 1'b0);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reload_done_drop got %0d exp 0", bus.done); end
    checks++; if (bus.res_min_cost !== 9'd300 || bus.res_cycles !== 24'd100) begin
      errors++; $display("FAIL reload_res_held got min=%0d cyc=%0d exp 300/100", bus.res_min_cost, bus.res_cycles); end
    for (int i = 1; i < 63; i++) send_beat(7'd7, 1'b0);
    send_beat(7'd7, 1'b1);
    checks++; if (bus.JAM_RST !== 1'b0) begin errors++; $display("FAIL reload_run got %0d exp 0", bus.JAM_RST); end
    bus.W = 3'd7; bus.J = 3'd7; #1;
    checks++; if (bus.Cost !== 7'd7) begin errors++; $display("FAIL reload_cost got %0d exp 7", bus.Cost); end
    checks++; if (bus.res_min_cost !== 9'd300 || bus.res_match_count !== 4'd2 || bus.res_cycles !== 24'd100) begin
      errors++; $display("FAIL reload_res_held_run got min=%0d cnt=%0d cyc=%0d exp 300/2/100", bus.res_min_cost, bus.res_match_count, bus.res_cycles); end
    bus.Valid = 1'b1; bus.MinCost = 9'd17; bus.MatchCount = 4'd5;
    tick();
    bus.Valid = 1'b0;
    checks++; if (bus.res_cycles !== 24'd1) begin errors++; $display("FAIL reload_res_cycles got %0d exp 1", bus.res_cycles); end
    checks++; if (bus.res_min_cost !== 9'd17 || bus.res_match_count !== 4'd5) begin
      errors++; $display("FAIL reload_res_new got min=%0d cnt=%0d exp 17/5", bus.res_min_cost, bus.res_match_count); end
  endtask

  // Starts in DONE, so the first beat also returns the block to LOAD.
  task automatic test_short_frame();
    for (int i = 0; i < 9; i++) send_beat(7'(i), 1'b0);
    checks++; if (bus.err_len !== 1'b0) begin errors++; $display("FAIL short_no_early_err got %0d exp 0", bus.err_len); end
    send_beat(7'd9, 1'b1);
    checks++; if (bus.err_len !== 1'b1) begin errors++; $display("FAIL short_err_pulse got %0d exp 1", bus.err_len); end
    checks++; if (bus.JAM_RST !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL short_stay_load got jam_rst=%0d ready=%0d exp 1/1", bus.JAM_RST, bus.in_ready); end
    tick();
    checks++; if (bus.err_len !== 1'b0) begin errors++; $display("FAIL short_err_one_cycle got %0d exp 0", bus.err_len); end
    for (int i = 0; i < 63; i++) send_beat(7'(63 - i), 1'b0);
    send_beat(7'd0, 1'b1);
    checks++; if (bus.JAM_RST !== 1'b0) begin errors++; $display("FAIL short_then_clean_run got %0d exp 0", bus.JAM_RST); end
    bus.W = 3'd0; bus.J = 3'd0; #1;
    checks++; if (bus.Cost !== 7'd63) begin errors++; $display("FAIL short_then_clean_cost got %0d exp 63", bus.Cost); end
  endtask

  task automatic test_reset_midframe();
    // Reset while JAM runs.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.JAM_RST !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_run_abort got jam_rst=%0d ready=%0d exp 1/1", bus.JAM_RST, bus.in_ready); end
    for (int i = 0; i < 30; i++) send_beat(7'd99, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.JAM_RST !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ctrl got ready=%0d jam_rst=%0d done=%0d exp 1/1/0", bus.in_ready, bus.JAM_RST, bus.done); end
    checks++; if (bus.res_cycles !== 24'd0 || bus.res_min_cost !== 9'd0 || bus.res_match_count !== 4'd0) begin
      errors++; $display("FAIL rst_mid_res got cyc=%0d min=%0d cnt=%0d exp 0/0/0", bus.res_cycles, bus.res_min_cost, bus.res_match_count); end
    // Full frame with random idle gaps; data = (5*i+3) mod 128.
    for (int i = 0; i < 64; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      repeat (gap) tick();
      send_beat(7'((5 * i + 3) % 128), (i == 63));
      if (i == 40) begin
        checks++; if (bus.JAM_RST !== 1'b1) begin errors++; $display("FAIL gap_jam_rst_mid got %0d exp 1", bus.JAM_RST); end
      end
    end
    checks++; if (bus.JAM_RST !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL gap_run got jam_rst=%0d ready=%0d exp 0/0", bus.JAM_RST, bus.in_ready); end
    bus.W = 3'd0; bus.J = 3'd0; #1;
    checks++; if (bus.Cost !== 7'd3) begin errors++; $display("FAIL gap_cost_w0j0 got %0d exp 3", bus.Cost); end
    bus.W = 3'd3; bus.J = 3'd5; #1;
    checks++; if (bus.Cost !== 7'd20) begin errors++; $display("FAIL gap_cost_w3j5 got %0d exp 20", bus.Cost); end
    bus.W = 3'd7; bus.J = 3'd7; #1;
    checks++; if (bus.Cost !== 7'd62) begin errors++; $display("FAIL gap_cost_w7j7 got %0d exp 62", bus.Cost); end
  endtask

  task automatic test_long_frame();
    bus.Valid = 1'b1; bus.MinCost = 9'd44; bus.MatchCount = 4'd1;
    tick();
    bus.Valid = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL long_pre_done got %0d exp 1", bus.done); end
    for (int i = 0; i < 63; i++) send_beat(7'd1, 1'b0);
    checks++; if (bus.err_len !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL long_beat63 got err=%0d done=%0d exp 0/0", bus.err_len, bus.done); end
    send_beat(7'd1, 1'b0);
    checks++; if (bus.err_len !== 1'b1) begin errors++; $display("FAIL long_err_pulse got %0d exp 1", bus.err_len); end
    checks++; if (bus.JAM_RST !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL long_no_run got jam_rst=%0d ready=%0d exp 1/1", bus.JAM_RST, bus.in_ready); end
    tick();
    checks++; if (bus.err_len !== 1'b0 || bus.JAM_RST !== 1'b1) begin
      errors++; $display("FAIL long_after got err=%0d jam_rst=%0d exp 0/1", bus.err_len, bus.JAM_RST); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.W = '0; bus.J = '0; bus.Valid = 1'b0; bus.MinCost = '0; bus.MatchCount = '0;
    test_reset();
    test_load();
    test_run_result();
    test_done_reload();
    test_short_frame();
    test_reset_midframe();
    test_long_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jam_cost_loader.md
# jam_cost_loader

Upstream feeder and result collector for the JAM job-assignment engine. It loads one 8×8 cost table (7-bit entries, row-major by worker) from a valid/ready stream. It then serves JAM's combinational W/J → Cost lookups and holds JAM in reset until a complete table is present. When JAM raises Valid, the block captures MinCost, MatchCount and the run length, and reports done.

## Interface
Parameters:
- WORKERS, 8, table rows (worker index W)
- JOBS, 8, table columns (job index J)
- COST_W, 7, cost entry width
- CYC_W, 24, run-cycle counter width

Ports:
- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  stream beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  COST_W  cost entry, order: W0J0, W0J1 … W7J7
- in_last  in  1  marks final beat of a table frame
- JAM_RST  out  1  registered reset to JAM; high whenever JAM must not run
- W  in  3  worker index from JAM
- J  in  3  job index from JAM
- Cost  out  COST_W  table[W*8+J], combinational
- Valid  in  1  JAM result valid
- MinCost  in  9  JAM minimum cost
- MatchCount  in  4  JAM count of assignments at MinCost
- done  out  1  result captured; level
- res_min_cost  out  9  captured MinCost
- res_match_count  out  4  captured MatchCount
- res_cycles  out  CYC_W  JAM run length in cycles
- err_len  out  1  one-cycle pulse when a frame is rejected

## Operation
- FSM has three states: LOAD, RUN, DONE. A beat is accepted when in_valid && in_ready.
- in_ready = 1 in LOAD and DONE; 0 in RUN.
- LOAD:
  - Each accepted beat writes table[wr_idx]; wr_idx (6 bits) then increments.
  - Beat with wr_idx==63 and in_last=1: go to RUN, clear wr_idx and the cycle counter.
  - Beat with in_last=1 and wr_idx<63 (short frame), or wr_idx==63 with in_last=0 (long frame): pulse err_len, set wr_idx=0, stay in LOAD. Already-written entries are not restored; the next frame overwrites them.
- RUN:
  - JAM_RST=0.
  - The cycle counter increments each cycle and saturates at all-ones.
  - Valid is ignored in all other states.
  - When Valid=1 is sampled:
    - res_min_cost ← MinCost, res_match_count ← MatchCount.
    - res_cycles ← counter+1, saturating.
    - done ← 1; go to DONE.
- DONE:
  - JAM_RST=1; results and done held.
  - The first accepted beat writes table[0], sets wr_idx=1, clears done and goes to LOAD. The same beat's in_last rules apply, so a 1-beat frame pulses err_len.
- Cost is table[{W,J}] in every state. Table storage is not reset; Cost content is undefined until the first full frame.
- W and J are 3 bits, so every index is in range.

## Timing
- Reset values: state LOAD, wr_idx 0, JAM_RST 1, in_ready 1, done 0, err_len 0, res_* 0, counter 0. The table is untouched.
- RST mid-frame or mid-RUN aborts everything immediately. JAM_RST is 1 from the edge that samples RST onward, and the partial frame is discarded.
- Final beat accepted at edge k: state RUN and JAM_RST=0 after edge k. in_ready=0 after edge k. Cost reflects entry 63 after edge k.
- JAM_RST low after edge k and Valid sampled at edge k+N: res_cycles=N, done=1 and JAM_RST=1 after edge k+N.
- err_len is high for exactly the cycle after the offending beat's edge.
- in_valid may stall any number of cycles between beats; wr_idx is unaffected.
- Throughput: one beat per cycle. Minimum load is 64 cycles.

## Test plan
- Load table entries = (8*w+j) mod 128 with no gaps; drive W=3,J=5. Expect Cost=29, and JAM_RST falling exactly after the 64th accept edge with in_ready=0.
- Short frame: in_last on beat 10. Expect err_len one-cycle pulse, state LOAD, JAM_RST=1. A following clean 64-beat frame enters RUN.
- In RUN, hold Valid=0 for 99 cycles, then Valid=1 with MinCost=300, MatchCount=2. Expect res_cycles=100, res_min_cost=300, res_match_count=2, done=1, JAM_RST=1 next cycle.
- Assert RST at beat 30 of a load. Expect in_ready=1, JAM_RST=1, done=0, res_*=0. Then a full 64-beat frame loads correctly with random in_valid gaps.
- From DONE, stream a second table with all entries 7. Expect done to drop on the first accept, Cost=7 for W=7,J=7 in RUN, and the previous results held until the new Valid.
- Long frame: 64 beats with no in_last. Expect err_len after beat 64, no RUN entry, JAM_RST stays 1.
